// File: rtl/fetch_pkg.sv
// Shared widths and the buffered fetch entry layout for the instruction fetch unit.
package fetch_pkg;

   localparam int unsigned INSTR_W = 18;
   localparam int unsigned ADDR_W  = 16;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush overrides push and pop.
// Head is read straight out of the storage registers, so a push is visible next cycle.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1),
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  fetch_entry_t       push_data,
   input  logic               pop,
   input  logic               flush,
   output fetch_entry_t       head,
   output logic [CNT_W-1:0]   count
);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr, rd_ptr_d;
   logic [CNT_W-1:0] count_d;
   logic             do_push;
   logic             do_pop;

   // Next pointer/occupancy; flush empties the buffer and drops any push/pop.
   always_comb begin
      do_pop   = pop && (count != '0) && !flush;
      do_push  = push && ((count < CNT_W'(DEPTH)) || do_pop) && !flush;
      wr_ptr_d = wr_ptr;
      rd_ptr_d = rd_ptr;
      count_d  = count;
      if (flush) begin
         rd_ptr_d = wr_ptr;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count + CNT_W'(1);
            2'b01:   count_d = count - CNT_W'(1);
            default: count_d = count;
         endcase
      end
   end

   // Pointer, occupancy and storage registers; storage clears on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         mem    <= '{default: '0};
      end else begin
         wr_ptr <= wr_ptr_d;
         rd_ptr <= rd_ptr_d;
         count  <= count_d;
         if (do_push) mem[wr_ptr] <= push_data;
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: sequential PC generation with credit-limited
// requests, in-order response tracking, stale-response dropping on redirect.
module instr_fetch_unit #(
   parameter int unsigned       DEPTH    = 4,
   parameter int unsigned       ADDR_W   = fetch_pkg::ADDR_W,
   parameter int unsigned       INSTR_W  = fetch_pkg::INSTR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req_o,
   output logic [ADDR_W-1:0]  imem_addr_o,
   input  logic               imem_rvalid_i,
   input  logic [INSTR_W-1:0] imem_rdata_i,
   input  logic               redirect_i,
   input  logic [ADDR_W-1:0]  redirect_pc_i,
   output logic               instr_valid_o,
   input  logic               instr_ready_i,
   output logic [INSTR_W-1:0] instr_o,
   output logic [ADDR_W-1:0]  instr_pc_o
);

   import fetch_pkg::*;

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
   logic [CNT_W-1:0]  outstanding, outstanding_d;
   logic [CNT_W-1:0]  drop_cnt, drop_cnt_d;
   logic [CNT_W-1:0]  count;
   logic [CNT_W:0]    in_use;
   logic              rsp_ok;
   logic              push;
   logic              pop;
   fetch_entry_t      push_data;
   fetch_entry_t      head;

   // Buffered plus in-flight entries bound new requests, so the buffer never overflows.
   assign in_use        = {1'b0, count} + {1'b0, outstanding};
   assign imem_req_o    = !reset && !redirect_i && (in_use < (CNT_W + 1)'(DEPTH));
   assign imem_addr_o   = pc_q;
   assign rsp_ok        = imem_rvalid_i && (outstanding != '0);
   assign instr_valid_o = (count != '0) && !redirect_i;
   assign pop           = instr_valid_o && instr_ready_i;
   assign push_data     = '{instr: imem_rdata_i, pc: resp_pc_q};
   assign instr_o       = head.instr;
   assign instr_pc_o    = head.pc;

   // Next PC, credit and drop bookkeeping; a redirect marks everything in flight as stale.
   always_comb begin
      pc_d          = pc_q;
      resp_pc_d     = resp_pc_q;
      outstanding_d = outstanding;
      drop_cnt_d    = drop_cnt;
      push          = 1'b0;
      if (redirect_i) begin
         pc_d          = redirect_pc_i;
         resp_pc_d     = redirect_pc_i;
         outstanding_d = outstanding - CNT_W'(rsp_ok);
         drop_cnt_d    = outstanding - CNT_W'(rsp_ok);
      end else begin
         if (imem_req_o) pc_d = pc_q + ADDR_W'(1);
         outstanding_d = outstanding + CNT_W'(imem_req_o) - CNT_W'(rsp_ok);
         if (rsp_ok) begin
            if (drop_cnt != '0) begin
               drop_cnt_d = drop_cnt - CNT_W'(1);
            end else begin
               push      = 1'b1;
               resp_pc_d = resp_pc_q + ADDR_W'(1);
            end
         end
      end
   end

   // Fetch state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q        <= RESET_PC;
         resp_pc_q   <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         pc_q        <= pc_d;
         resp_pc_q   <= resp_pc_d;
         outstanding <= outstanding_d;
         drop_cnt    <= drop_cnt_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (redirect_i),
      .head      (head),
      .count     (count)
   );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit with an in-order memory model and a
// delivered-stream reference model (tagged in-flight requests, expected buffer queue).
module tb_instr_fetch_unit;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_o;
   logic [15:0] imem_addr_o;
   logic        imem_rvalid_i;
   logic [17:0] imem_rdata_i;
   logic        redirect_i;
   logic [15:0] redirect_pc_i;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic [17:0] instr_o;
   logic [15:0] instr_pc_o;

   instr_fetch_unit #(
      .DEPTH    (DEPTH),
      .ADDR_W   (16),
      .INSTR_W  (18),
      .RESET_PC (16'h0000)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .instr_valid_o (instr_valid_o),
      .instr_ready_i (instr_ready_i),
      .instr_o       (instr_o),
      .instr_pc_o    (instr_pc_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      int          due;
      bit          stale;
   } req_t;

   typedef struct {
      logic [17:0] instr;
      logic [15:0] pc;
   } ent_t;

   req_t        inflight[$];
   ent_t        mq[$];
   int          cyc;
   int          n_checks;
   int          n_fail;
   logic [15:0] exp_fetch_pc;
   int          lat_min, lat_max;
   bit          rdy_n, redir_n;
   logic [15:0] rpc_n;

   function automatic logic [17:0] mem_data(logic [15:0] a);
      return {a[1:0], a} ^ 18'h25A5A;
   endfunction

   function automatic int stale_count();
      int n = 0;
      foreach (inflight[i]) if (inflight[i].stale) n++;
      return n;
   endfunction

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock cycle: drive inputs, check outputs at negedge, advance the model.
   task automatic cycle();
      bit   rv, er, ev;
      req_t r;
      ent_t e;
      rv = (inflight.size() > 0) && (inflight[0].due <= cyc);
      imem_rvalid_i = rv;
      imem_rdata_i  = rv ? mem_data(inflight[0].addr) : 18'($urandom);
      redirect_i    = redir_n;
      redirect_pc_i = rpc_n;
      instr_ready_i = rdy_n;
      @(negedge clk);
      er = !redir_n && ((mq.size() + inflight.size()) < DEPTH);
      ev = !redir_n && (mq.size() > 0);
      check("req", 32'(imem_req_o), 32'(er));
      if (er) check("addr", 32'(imem_addr_o), 32'(exp_fetch_pc));
      check("valid", 32'(instr_valid_o), 32'(ev));
      if (ev) begin
         check("instr", 32'(instr_o), 32'(mq[0].instr));
         check("pc", 32'(instr_pc_o), 32'(mq[0].pc));
      end
      if (ev && rdy_n) void'(mq.pop_front());
      if (rv) begin
         r = inflight.pop_front();
         if (!r.stale && !redir_n) begin
            e.instr = mem_data(r.addr);
            e.pc    = r.addr;
            mq.push_back(e);
         end
      end
      if (er) begin
         r.addr  = exp_fetch_pc;
         r.due   = cyc + int'($urandom_range(lat_max, lat_min));
         r.stale = 1'b0;
         inflight.push_back(r);
         exp_fetch_pc = exp_fetch_pc + 16'd1;
      end
      if (redir_n) begin
         mq.delete();
         foreach (inflight[i]) inflight[i].stale = 1'b1;
         exp_fetch_pc = rpc_n;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Assert reset between edges, check outputs clear at once, release after an edge.
   task automatic do_reset();
      reset         = 1'b1;
      redirect_i    = 1'b0;
      instr_ready_i = 1'b0;
      imem_rvalid_i = 1'b0;
      #1;
      check("rst_req", 32'(imem_req_o), 32'd0);
      check("rst_addr", 32'(imem_addr_o), 32'h0000);
      check("rst_valid", 32'(instr_valid_o), 32'd0);
      check("rst_instr", 32'(instr_o), 32'd0);
      check("rst_pc", 32'(instr_pc_o), 32'd0);
      check("rst_count", 32'(dut.count), 32'd0);
      inflight.delete();
      mq.delete();
      exp_fetch_pc = 16'h0000;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail = 0;
      cyc = 0;
      reset = 1'b1;
      redirect_i = 1'b0;
      redirect_pc_i = 16'h0;
      instr_ready_i = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i = '0;
      redir_n = 1'b0;
      rpc_n = 16'h0;
      rdy_n = 1'b1;
      lat_min = 1;
      lat_max = 1;
      do_reset();

      // Streaming with 1-cycle memory, always-ready consumer.
      repeat (20) cycle();

      // Stalled consumer fills the buffer and halts requests.
      rdy_n = 1'b0;
      repeat (20) cycle();
      check("full_count", 32'(dut.count), 32'(DEPTH));
      rdy_n = 1'b1;
      repeat (20) cycle();

      // 3-cycle memory, redirect with three requests in flight.
      lat_min = 3;
      lat_max = 3;
      for (int i = 0; i < 40 && inflight.size() != 3; i++) cycle();
      check("outstanding3", 32'(dut.outstanding), 32'd3);
      redir_n = 1'b1;
      rpc_n = 16'h0100;
      cycle();
      redir_n = 1'b0;
      check("drop_after_redirect", 32'(dut.drop_cnt), 32'(stale_count()));
      repeat (20) cycle();

      // Redirect coinciding with a response and a pop attempt.
      lat_min = 2;
      lat_max = 2;
      repeat (10) cycle();
      for (int i = 0; i < 20; i++) begin
         if (inflight.size() > 0 && inflight[0].due <= cyc && mq.size() > 0) break;
         cycle();
      end
      redir_n = 1'b1;
      rpc_n = 16'h0200;
      cycle();
      redir_n = 1'b0;
      check("drop_same_cycle", 32'(dut.drop_cnt), 32'(stale_count()));
      repeat (12) cycle();

      // PC wrap.
      lat_min = 1;
      lat_max = 1;
      redir_n = 1'b1;
      rpc_n = 16'hFFFE;
      cycle();
      redir_n = 1'b0;
      repeat (15) cycle();

      // Reset mid-stream with two buffered entries.
      redir_n = 1'b1;
      rpc_n = 16'h0040;
      cycle();
      redir_n = 1'b0;
      rdy_n = 1'b0;
      for (int i = 0; i < 20 && mq.size() != 2; i++) cycle();
      check("count2", 32'(dut.count), 32'd2);
      do_reset();
      rdy_n = 1'b1;
      repeat (15) cycle();

      // Random traffic: variable latency, back-pressure, redirects.
      lat_min = 1;
      lat_max = 4;
      for (int i = 0; i < 3000; i++) begin
         rdy_n   = ($urandom_range(3, 0) != 0);
         redir_n = ($urandom_range(32, 0) == 0);
         rpc_n   = 16'($urandom);
         cycle();
      end
      redir_n = 1'b0;
      rdy_n = 1'b1;
      repeat (20) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-fetch front end for the out-of-order pipelined processor. It generates sequential word addresses to instruction memory, tracks in-order variable-latency responses, and buffers the returned 18-bit instructions. It delivers them with their PCs to decode/dispatch over a valid/ready handshake. Branch redirects from the datapath flush the buffer and discard every stale in-flight response.

## Interface
Parameters:
- DEPTH, 4, instruction buffer entries and maximum outstanding memory requests (power of two, ≥2)
- ADDR_W, 16, PC width; word-addressed
- INSTR_W, 18, instruction width
- RESET_PC, 0, PC after reset

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- imem_req_o  out  1  fetch request; memory accepts every request
- imem_addr_o  out  ADDR_W  fetch word address
- imem_rvalid_i  in  1  response valid; responses return in request order, latency ≥1
- imem_rdata_i  in  INSTR_W  response instruction
- redirect_i  in  1  branch redirect pulse
- redirect_pc_i  in  ADDR_W  new fetch PC
- instr_valid_o  out  1  buffer head valid
- instr_ready_i  in  1  consumer accepts head
- instr_o  out  INSTR_W  head instruction
- instr_pc_o  out  ADDR_W  PC of head instruction

## Operation
- State: pc_q (next fetch address), resp_pc_q (PC of next accepted response), count (buffer occupancy), outstanding (issued requests with no response yet), drop_cnt (stale responses still to discard).
- Request: imem_req_o = !redirect_i && (count + outstanding < DEPTH). imem_addr_o = pc_q. Each request sets pc_q to pc_q+1, wrapping mod 2^ADDR_W. Stale in-flight requests consume credit, so the buffer can never overflow.
- Response: each rvalid decrements outstanding.
  - If drop_cnt>0, the data is discarded and drop_cnt decrements.
  - Otherwise {imem_rdata_i, resp_pc_q} is pushed and resp_pc_q increments, with wrap.
- If rvalid arrives while outstanding==0, it is a protocol violation and is ignored; no counters change.
- Pop: a pop occurs when instr_valid_o && instr_ready_i. Push and pop in the same cycle leave count unchanged.
- Redirect, when redirect_i=1:
  - count←0.
  - pc_q←redirect_pc_i; resp_pc_q←redirect_pc_i.
  - drop_cnt←outstanding − imem_rvalid_i. A response arriving in the redirect cycle is itself discarded.
  - No request is issued that cycle.
  - instr_valid_o is gated to 0 that cycle, so no pop occurs.
- Reset mid-operation: all state returns to reset values immediately. The memory side must also be reset, because responses still in flight are not tracked.

## Timing
- Reset values:
  - imem_req_o=0, imem_addr_o=RESET_PC.
  - instr_valid_o=0, instr_o=0, instr_pc_o=0 (storage resets to 0).
  - count=outstanding=drop_cnt=0.
- The first request (addr RESET_PC) is asserted in the first cycle after reset deasserts.
- Buffer is registered. A response accepted in cycle T appears on instr_o/instr_valid_o in T+1.
- Redirect in cycle T:
  - Request for redirect_pc_i in T+1.
  - With 1-cycle memory and no stale traffic: rvalid in T+2, instr_valid_o in T+3.
- Full buffer (count=DEPTH) means imem_req_o=0. With a consumer that is always ready and 1-cycle memory, throughput is one instruction per cycle.
- Counters: count and outstanding are $clog2(DEPTH+1) bits; drop_cnt has the same width.

## Structure
- Package fetch_pkg holds:
  - INSTR_W and ADDR_W defaults.
  - typedef fetch_entry_t packed {instr, pc}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with DEPTH entries.
  - Ports: push, pop, flush, registered head, count.
  - Flush has priority over push/pop.
- The top module holds the PC, credit and drop logic.

## Test plan
- Reset, 1-cycle memory, ready always 1:
  - Addresses 0,1,2,3… issued on consecutive cycles.
  - instr_pc_o = 0,1,2… with data matching, one per cycle.
- instr_ready_i=0 for 20 cycles:
  - Exactly DEPTH=4 requests are issued; count=4; imem_req_o stays 0.
  - After ready returns, there are no lost or duplicated instructions.
- 3-cycle memory latency, redirect to 0x0100 while outstanding=3:
  - The next 3 responses are dropped.
  - The first delivered instruction has instr_pc_o=0x0100.
- Redirect in the same cycle as rvalid and as a pop attempt:
  - The response is discarded and the pop is ignored.
  - instr_valid_o=0 next cycle; drop_cnt = outstanding−1.
- PC wrap: redirect to 0xFFFE:
  - Delivered PCs are 0xFFFE, 0xFFFF, 0x0000.
- Assert reset mid-stream with count=2:
  - Outputs immediately return to reset values.
  - Fetch resumes at RESET_PC.
